vga_text_ctrl: RTL and testbench

VGA_TEXT_CTRL -- requirements
Module: vga_text_ctrl

---
 rtl/vga_text_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_vga_text_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_ctrl.sv
// Text-mode VGA scan generator with an 80x60 character buffer cleared to spaces after reset.
// Define VGA_TEXT_CURSOR_EN to build the blinking cursor overlay driven by cur_addr.
module vga_text_ctrl #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        vgaclk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [12:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic [12:0] cur_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [7:0]  char,
    output logic        frame_start
);

    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SYNC    = 10'd96;
    localparam logic [9:0]  V_SYNC    = 10'd2;
    localparam logic [9:0]  H_VIS_LO  = 10'd145;
    localparam logic [9:0]  H_VIS_HI  = 10'd784;
    localparam logic [9:0]  V_VIS_LO  = 10'd35;
    localparam logic [9:0]  V_VIS_HI  = 10'd514;
    localparam logic [12:0] CELLS     = 13'd4800;
    localparam logic [12:0] LAST_CELL = 13'd4799;
    localparam logic [7:0]  SPACE     = 8'd32;
    localparam logic [7:0]  CURSOR_CH = 8'd43;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [12:0] clr_idx_r;
    logic [12:0] clr_idx_s;
    logic        wr_ready_r;

    logic [9:0]  hcnt_r;
    logic [9:0]  vcnt_r;
    logic        vis_s;
    logic [6:0]  col_s;
    logic [5:0]  row_s;
    logic [12:0] rd_idx_s;
    logic        cursor_hit_s;

    logic        mem_we_s;
    logic [12:0] mem_wa_s;
    logic [7:0]  mem_wd_s;
    logic [7:0]  mem [0:4799];

    logic [9:0]  x_r;
    logic [9:0]  y_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        blank_n_r;
    logic        frame_start_r;
    logic [7:0]  char_r;

    // Raster counters: hcnt wraps every line, vcnt advances on each hcnt wrap.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            hcnt_r <= 10'd0;
            vcnt_r <= 10'd0;
        end else if (hcnt_r == H_LAST) begin
            hcnt_r <= 10'd0;
            if (vcnt_r == V_LAST) begin
                vcnt_r <= 10'd0;
            end else begin
                vcnt_r <= vcnt_r + 10'd1;
            end
        end else begin
            hcnt_r <= hcnt_r + 10'd1;
        end
    end

    // Visible-window decode and cell index; row*80 is built as row*64 + row*16.
    always_comb begin
        vis_s    = (hcnt_r >= H_VIS_LO) && (hcnt_r <= H_VIS_HI) &&
                   (vcnt_r >= V_VIS_LO) && (vcnt_r <= V_VIS_HI);
        col_s    = 7'((hcnt_r - H_VIS_LO) >> 3'd3);
        row_s    = 6'((vcnt_r - V_VIS_LO) >> 3'd3);
        rd_idx_s = {1'b0, row_s, 6'b0} + {3'b0, row_s, 4'b0} + {6'b0, col_s};
    end

    // Clear sequencer next state and the single buffer write port.
    always_comb begin
        state_s   = state_r;
        clr_idx_s = clr_idx_r;
        mem_we_s  = 1'b0;
        mem_wa_s  = wr_addr;
        mem_wd_s  = wr_data;
        case (state_r)
            CLEAR: begin
                mem_we_s = 1'b1;
                mem_wa_s = clr_idx_r;
                mem_wd_s = SPACE;
                if (clr_idx_r == LAST_CELL) begin
                    state_s   = RUN;
                    clr_idx_s = 13'd0;
                end else begin
                    clr_idx_s = clr_idx_r + 13'd1;
                end
            end
            RUN: begin
                if (wr_en && (wr_addr < CELLS)) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_s   = CLEAR;
                clr_idx_s = 13'd0;
            end
        endcase
    end

    // Clear sequencer state register; wr_ready follows the state being entered.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            state_r    <= CLEAR;
            clr_idx_r  <= 13'd0;
            wr_ready_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            clr_idx_r  <= clr_idx_s;
            wr_ready_r <= (state_s == RUN);
        end
    end

    // Buffer write; the display read in the output stage samples the pre-write content.
    always_ff @(posedge vgaclk) begin
        if (mem_we_s) begin
            mem[mem_wa_s] <= mem_wd_s;
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    logic [15:0] blink_cnt_r;
    logic        blink_on_r;

    // Frame counter toggling the cursor phase; the phase starts visible after reset.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            blink_cnt_r <= 16'd0;
            blink_on_r  <= 1'b1;
        end else if ((hcnt_r == H_LAST) && (vcnt_r == V_LAST)) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= 16'd0;
                blink_on_r  <= ~blink_on_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 16'd1;
            end
        end
    end

    assign cursor_hit_s = blink_on_r && (rd_idx_s == cur_addr);
`else
    logic unused_cursor_s;

    assign cursor_hit_s    = 1'b0;
    assign unused_cursor_s = ^{cur_addr, 32'(BLINK_FRAMES)};
`endif

    // Output stage: everything is one cycle behind the counters so char lines up with x,y.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            x_r           <= 10'd0;
            y_r           <= 10'd0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            blank_n_r     <= 1'b0;
            frame_start_r <= 1'b0;
            char_r        <= SPACE;
        end else begin
            x_r           <= hcnt_r;
            y_r           <= vcnt_r;
            hsync_r       <= (hcnt_r >= H_SYNC);
            vsync_r       <= (vcnt_r >= V_SYNC);
            blank_n_r     <= vis_s;
            frame_start_r <= (hcnt_r == 10'd0) && (vcnt_r == 10'd0);
            if (!vis_s) begin
                char_r <= SPACE;
            end else if (cursor_hit_s) begin
                char_r <= CURSOR_CH;
            end else begin
                char_r <= mem[rd_idx_s];
            end
        end
    end

    assign wr_ready    = wr_ready_r;
    assign x           = x_r;
    assign y           = y_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign blank_n     = blank_n_r;
    assign frame_start = frame_start_r;
    assign char        = char_r;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Directed self-checking bench for vga_text_ctrl, run with a shortened raster (170x52)
// so that every visible-window boundary and whole frames fit in a short simulation.
`timescale 1ns/1ps
module tb_vga_text_ctrl;

    localparam int HT        = 170;
    localparam int VT        = 52;
    localparam int FRAME     = HT * VT;
    localparam int BLINK     = 1;
    localparam int VIS_CELLS = (HT - 145) * (VT - 35);

    logic        vgaclk   = 1'b0;
    logic        reset    = 1'b1;
    logic        wr_en    = 1'b0;
    logic [12:0] wr_addr  = 13'd0;
    logic [7:0]  wr_data  = 8'd0;
    logic [12:0] cur_addr = 13'd0;
    logic        wr_ready;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  char;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    vga_text_ctrl #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .BLINK_FRAMES(BLINK)
    ) dut (
        .vgaclk     (vgaclk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .cur_addr   (cur_addr),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank_n    (blank_n),
        .x          (x),
        .y          (y),
        .char       (char),
        .frame_start(frame_start)
    );

    always #5 vgaclk = ~vgaclk;

    task automatic test_reset();
        int zeros;
        int drops;
        int vis;
        int bad_chars;
        bit seen_ready;
        reset = 1'b0;
        repeat (300) @(negedge vgaclk);
        reset = 1'b1;
        #1;
        total++; if (x !== 10'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", x); end
        total++; if (y !== 10'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", y); end
        total++; if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        total++; if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        total++; if (blank_n !== 1'b0) begin bad++; $display("FAIL reset_blank_n: got %b want 0", blank_n); end
        total++; if (char !== 8'd32) begin bad++; $display("FAIL reset_char: got %0d want 32", char); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        @(negedge vgaclk);
        reset = 1'b0;
        #1;
        zeros = (wr_ready === 1'b0) ? 1 : 0;
        drops = 0; vis = 0; bad_chars = 0; seen_ready = 1'b0;
        @(negedge vgaclk);
        total++;
        if (frame_start !== 1'b1 || x !== 10'd0 || y !== 10'd0) begin
            bad++; $display("FAIL reset_scan_origin: got fs=%b x=%0d y=%0d want fs=1 x=0 y=0", frame_start, x, y);
        end
        for (int i = 0; i < FRAME; i++) begin
            if (!seen_ready) begin
                if (wr_ready === 1'b1) seen_ready = 1'b1;
                else zeros++;
            end else if (wr_ready !== 1'b1) begin
                drops++;
            end
            if (blank_n === 1'b1) begin
                vis++;
                if (char !== 8'd32) bad_chars++;
            end
            @(negedge vgaclk);
        end
        total++; if (zeros !== 4800) begin bad++; $display("FAIL clear_wr_ready_low: got %0d cycles want 4800", zeros); end
        total++; if (drops !== 0) begin bad++; $display("FAIL wr_ready_drops: got %0d want 0", drops); end
        total++; if (vis !== VIS_CELLS) begin bad++; $display("FAIL first_frame_visible: got %0d want %0d", vis, VIS_CELLS); end
        total++; if (bad_chars !== 0) begin bad++; $display("FAIL first_frame_spaces: got %0d non-space want 0", bad_chars); end
    endtask

    task automatic test_timing();
        int ex; int ey;
        int e_xy; int e_hs; int e_vs; int e_bl; int e_fs;
        int hs_low; int vs_low; int fs_cnt;
        logic exp_hs; logic exp_vs; logic exp_bl; logic exp_fs;
        ex = 0; ey = 0;
        e_xy = 0; e_hs = 0; e_vs = 0; e_bl = 0; e_fs = 0;
        hs_low = 0; vs_low = 0; fs_cnt = 0;
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_period_start: got %b want 1", frame_start); end
        for (int i = 0; i < FRAME; i++) begin
            exp_hs = (ex >= 96);
            exp_vs = (ey >= 2);
            exp_bl = (ex >= 145) && (ex <= 784) && (ey >= 35) && (ey <= 514);
            exp_fs = (ex == 0) && (ey == 0);
            if (x !== 10'(ex) || y !== 10'(ey)) e_xy++;
            if (hsync !== exp_hs) e_hs++;
            if (vsync !== exp_vs) e_vs++;
            if (blank_n !== exp_bl) e_bl++;
            if (frame_start !== exp_fs) e_fs++;
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (frame_start === 1'b1) fs_cnt++;
            @(negedge vgaclk);
            ex++;
            if (ex == HT) begin
                ex = 0; ey++;
                if (ey == VT) ey = 0;
            end
        end
        total++; if (e_xy !== 0) begin bad++; $display("FAIL scan_xy: got %0d mismatching cycles want 0", e_xy); end
        total++; if (e_hs !== 0) begin bad++; $display("FAIL hsync_shape: got %0d mismatching cycles want 0", e_hs); end
        total++; if (e_vs !== 0) begin bad++; $display("FAIL vsync_shape: got %0d mismatching cycles want 0", e_vs); end
        total++; if (e_bl !== 0) begin bad++; $display("FAIL blank_window: got %0d mismatching cycles want 0", e_bl); end
        total++; if (e_fs !== 0) begin bad++; $display("FAIL frame_start_shape: got %0d mismatching cycles want 0", e_fs); end
        total++; if (hs_low !== 96 * VT) begin bad++; $display("FAIL hsync_low_total: got %0d want %0d", hs_low, 96 * VT); end
        total++; if (vs_low !== 2 * HT) begin bad++; $display("FAIL vsync_low_total: got %0d want %0d", vs_low, 2 * HT); end
        total++; if (fs_cnt !== 1) begin bad++; $display("FAIL frame_start_count: got %0d want 1", fs_cnt); end
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_period_end: got %b want 1", frame_start); end
    endtask

    task automatic test_write_display();
        int hits; int bad_in; int edge_n; int bad_edge;
        wr_addr = 13'd81; wr_data = 8'd65; wr_en = 1'b1;
        @(negedge vgaclk);
        wr_en = 1'b0;
        hits = 0; bad_in = 0; edge_n = 0; bad_edge = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (x >= 153 && x <= 160 && y >= 43 && y <= 50) begin
                hits++;
                if (char !== 8'd65 || blank_n !== 1'b1) bad_in++;
            end else if (((x == 152 || x == 161) && y >= 43 && y <= 50) ||
                         ((y == 42 || y == 51) && x >= 153 && x <= 160)) begin
                edge_n++;
                if (char !== 8'd32) bad_edge++;
            end
            @(negedge vgaclk);
        end
        total++; if (hits !== 64) begin bad++; $display("FAIL write_cell_pixels: got %0d want 64", hits); end
        total++; if (bad_in !== 0) begin bad++; $display("FAIL write_cell_char: got %0d bad pixels want 0", bad_in); end
        total++; if (edge_n !== 32) begin bad++; $display("FAIL write_edge_pixels: got %0d want 32", edge_n); end
        total++; if (bad_edge !== 0) begin bad++; $display("FAIL write_edge_char: got %0d bad pixels want 0", bad_edge); end
    endtask

    task automatic test_illegal_writes();
        int n; int vis; int bad_chars;
        reset = 1'b1;
        repeat (2) @(negedge vgaclk);
        reset = 1'b0;
        repeat (100) @(negedge vgaclk);
        wr_addr = 13'd2; wr_data = 8'd90; wr_en = 1'b1;
        @(negedge vgaclk);
        wr_en = 1'b0;
        n = 0;
        while (wr_ready !== 1'b1 && n < 6000) begin
            @(negedge vgaclk);
            n++;
        end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready_timeout: got %b want 1", wr_ready); end
        wr_addr = 13'd4800; wr_data = 8'd81; wr_en = 1'b1;
        @(negedge vgaclk);
        wr_en = 1'b0;
        vis = 0; bad_chars = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (blank_n === 1'b1) begin
                vis++;
                if (char !== 8'd32) bad_chars++;
            end
            @(negedge vgaclk);
        end
        total++; if (vis !== VIS_CELLS) begin bad++; $display("FAIL illegal_visible: got %0d want %0d", vis, VIS_CELLS); end
        total++; if (bad_chars !== 0) begin bad++; $display("FAIL illegal_unchanged: got %0d non-space want 0", bad_chars); end
    endtask

    task automatic test_read_first();
        int n;
        n = 0;
        while (!(x === 10'd144 && y === 10'd35) && n < 2 * FRAME) begin
            @(negedge vgaclk);
            n++;
        end
        total++;
        if (!(x === 10'd144 && y === 10'd35)) begin
            bad++; $display("FAIL rf_find: got x=%0d y=%0d want x=144 y=35", x, y);
            return;
        end
        wr_addr = 13'd0; wr_data = 8'd66; wr_en = 1'b1;
        @(negedge vgaclk);
        wr_en = 1'b0;
        total++;
        if (x !== 10'd145 || y !== 10'd35 || char !== 8'd32) begin
            bad++; $display("FAIL rf_old_value: got x=%0d y=%0d char=%0d want x=145 y=35 char=32", x, y, char);
        end
        @(negedge vgaclk);
        total++;
        if (x !== 10'd146 || char !== 8'd66) begin
            bad++; $display("FAIL rf_next_read: got x=%0d char=%0d want x=146 char=66", x, char);
        end
        n = 0;
        while (!(x === 10'd145 && y === 10'd35) && n < 2 * FRAME) begin
            @(negedge vgaclk);
            n++;
        end
        total++;
        if (char !== 8'd66 || x !== 10'd145 || y !== 10'd35) begin
            bad++; $display("FAIL rf_next_frame: got x=%0d y=%0d char=%0d want x=145 y=35 char=66", x, y, char);
        end
    endtask

    task automatic test_cursor();
        int n; int fidx; int checks;
        logic [7:0] exp_c;
        cur_addr = 13'd0;
        reset = 1'b1;
        repeat (2) @(negedge vgaclk);
        reset = 1'b0;
        n = 0;
        while (wr_ready !== 1'b1 && n < 6000) begin
            @(negedge vgaclk);
            n++;
        end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL cursor_ready_timeout: got %b want 1", wr_ready); end
        wr_addr = 13'd0; wr_data = 8'd67; wr_en = 1'b1;
        @(negedge vgaclk);
        wr_en = 1'b0;
        fidx = 0; checks = 0; n = 0;
        while (fidx < 2 && n < 3 * FRAME) begin
            if (frame_start === 1'b1) fidx++;
            if (fidx < 2 && x === 10'd145 && y === 10'd35) begin
`ifdef VGA_TEXT_CURSOR_EN
                exp_c = (((fidx / BLINK) % 2) == 0) ? 8'd43 : 8'd67;
`else
                exp_c = 8'd67;
`endif
                checks++;
                total++;
                if (char !== exp_c) begin
                    bad++; $display("FAIL cursor_cell_frame%0d: got %0d want %0d", fidx, char, exp_c);
                end
            end
            if (fidx < 2 && x === 10'd153 && y === 10'd35) begin
                total++;
                if (char !== 8'd32) begin
                    bad++; $display("FAIL cursor_neighbour_frame%0d: got %0d want 32", fidx, char);
                end
            end
            @(negedge vgaclk);
            n++;
        end
        total++; if (checks !== 2) begin bad++; $display("FAIL cursor_frames_seen: got %0d want 2", checks); end
    endtask

    initial begin
        repeat (3) @(negedge vgaclk);
        test_reset();
        test_timing();
        test_write_display();
        test_illegal_writes();
        test_read_first();
        test_cursor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
